// File: rtl/vec_exe_pkg.sv
// Shared types and constants for the vector execute sequencer.
package vec_exe_pkg;

    localparam int WIDTH = 16;
    localparam int LANES = 4;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_ROL = 4'd7,
        ALU_ROR = 4'd8
    } alu_op_e;

    // state   | meaning
    // IDLE    | accepting: scalars complete here, vectors are captured
    // RUN     | lanes 0..2 evaluated one per cycle into the lane buffer
    // DONE    | lane 3 evaluated and the whole bundle loaded to outputs
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// Shared combinational ALU used by both scalar and lane-serial vector ops.
module vec_lane_alu
    import vec_exe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result
);

    logic [3:0]         amount;
    logic [2*WIDTH-1:0] rol_dbl;
    logic [2*WIDTH-1:0] ror_dbl;

    // Rotates are taken from a doubled operand so no wrap-around logic is needed.
    always_comb begin
        amount  = op2[3:0];
        rol_dbl = {op1, op1} << amount;
        ror_dbl = {op1, op1} >> amount;
        case (alu_control)
            ALU_ADD: result = op1 + op2;
            ALU_SUB: result = op1 - op2;
            ALU_AND: result = op1 & op2;
            ALU_OR:  result = op1 | op2;
            ALU_XOR: result = op1 ^ op2;
            ALU_SLL: result = op1 << amount;
            ALU_SRL: result = op1 >> amount;
            ALU_ROL: result = rol_dbl[2*WIDTH-1:WIDTH];
            ALU_ROR: result = ror_dbl[WIDTH-1:0];
            default: result = op1;
        endcase
    end

endmodule

// File: rtl/vec_exe_sequencer.sv
// Execute stage: scalar ops in one cycle, vector ops lane-serially on one ALU.
module vec_exe_sequencer
    import vec_exe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int RD_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vec_in,
    input  logic             regWrite_in,
    input  logic             memWrite_in,
    input  logic             branch_in,
    input  logic             resultSrc_in,
    input  logic             updateCount_in,
    input  logic [3:0]       aluControl_in,
    input  logic [RD_W-1:0]  rd_in,
    input  logic [WIDTH-1:0] op1_in,
    input  logic [WIDTH-1:0] op2_in,
    input  logic [WIDTH-1:0] op01_in,
    input  logic [WIDTH-1:0] op02_in,
    input  logic [WIDTH-1:0] op11_in,
    input  logic [WIDTH-1:0] op12_in,
    input  logic [WIDTH-1:0] op21_in,
    input  logic [WIDTH-1:0] op22_in,
    input  logic [WIDTH-1:0] op31_in,
    input  logic [WIDTH-1:0] op32_in,
    input  logic             hold_in,
    output logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] res_out,
    output logic [WIDTH-1:0] res0_out,
    output logic [WIDTH-1:0] res1_out,
    output logic [WIDTH-1:0] res2_out,
    output logic [WIDTH-1:0] res3_out,
    output logic [RD_W-1:0]  rd_out,
    output logic             vec_out,
    output logic             regWrite_out,
    output logic             memWrite_out,
    output logic             resultSrc_out,
    output logic             updateCount_out,
    output logic             branch_taken_out
);

    localparam int CNT_W = $clog2(LANES);
    // Last lane handled in RUN; the final lane is evaluated in DONE.
    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(LANES - 2);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   lane_cnt;
    logic [WIDTH-1:0]   a_q [LANES];
    logic [WIDTH-1:0]   b_q [LANES];
    logic [WIDTH-1:0]   lane_buf [LANES-1];
    logic [3:0]         ctrl_q;
    logic [RD_W-1:0]    rd_q;
    logic               rw_q, mw_q, rs_q, uc_q, bt_q;

    logic               valid_in;
    logic               accept_scalar, accept_vec, lane_step, finish;
    logic [WIDTH-1:0]   alu_a, alu_b, alu_res;
    logic [3:0]         alu_ctrl;

    assign valid_in = regWrite_in | memWrite_in | branch_in | updateCount_in;
    assign stall    = (state != ST_IDLE) | hold_in;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and datapath strobes; everything freezes while held.
    always_comb begin
        state_nxt     = state;
        accept_scalar = 1'b0;
        accept_vec    = 1'b0;
        lane_step     = 1'b0;
        finish        = 1'b0;
        if (!hold_in) begin
            case (state)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (vec_in) begin
                            accept_vec = 1'b1;
                            state_nxt  = ST_RUN;
                        end else begin
                            accept_scalar = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    lane_step = 1'b1;
                    if (lane_cnt == LAST_RUN) state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // ALU operands: live scalar inputs in IDLE, captured lane pair otherwise.
    always_comb begin
        if (state == ST_IDLE) begin
            alu_a    = op1_in;
            alu_b    = op2_in;
            alu_ctrl = aluControl_in;
        end else begin
            alu_a    = a_q[lane_cnt];
            alu_b    = b_q[lane_cnt];
            alu_ctrl = ctrl_q;
        end
    end

    vec_lane_alu #(.WIDTH(WIDTH)) u_alu (
        .op1         (alu_a),
        .op2         (alu_b),
        .alu_control (alu_ctrl),
        .result      (alu_res)
    );

    // Capture, lane buffer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_cnt         <= '0;
            ctrl_q           <= '0;
            rd_q             <= '0;
            {rw_q, mw_q, rs_q, uc_q, bt_q} <= '0;
            for (int i = 0; i < LANES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int i = 0; i < LANES - 1; i++) lane_buf[i] <= '0;
            out_valid        <= 1'b0;
            res_out          <= '0;
            res0_out         <= '0;
            res1_out         <= '0;
            res2_out         <= '0;
            res3_out         <= '0;
            rd_out           <= '0;
            vec_out          <= 1'b0;
            regWrite_out     <= 1'b0;
            memWrite_out     <= 1'b0;
            resultSrc_out    <= 1'b0;
            updateCount_out  <= 1'b0;
            branch_taken_out <= 1'b0;
        end else if (!hold_in) begin
            out_valid <= accept_scalar | finish;
            if (accept_scalar) begin
                res_out          <= alu_res;
                rd_out           <= rd_in;
                vec_out          <= 1'b0;
                regWrite_out     <= regWrite_in;
                memWrite_out     <= memWrite_in;
                resultSrc_out    <= resultSrc_in;
                updateCount_out  <= updateCount_in;
                branch_taken_out <= branch_in & (op1_in == op2_in);
            end
            if (accept_vec) begin
                a_q[0]   <= op01_in;  b_q[0] <= op02_in;
                a_q[1]   <= op11_in;  b_q[1] <= op12_in;
                a_q[2]   <= op21_in;  b_q[2] <= op22_in;
                a_q[3]   <= op31_in;  b_q[3] <= op32_in;
                ctrl_q   <= aluControl_in;
                rd_q     <= rd_in;
                rw_q     <= regWrite_in;
                mw_q     <= memWrite_in;
                rs_q     <= resultSrc_in;
                uc_q     <= updateCount_in;
                bt_q     <= branch_in & (op1_in == op2_in);
                lane_cnt <= '0;
            end
            if (lane_step) begin
                lane_buf[lane_cnt] <= alu_res;
                lane_cnt           <= lane_cnt + 1'b1;
            end
            if (finish) begin
                res0_out         <= lane_buf[0];
                res1_out         <= lane_buf[1];
                res2_out         <= lane_buf[2];
                res3_out         <= alu_res;
                rd_out           <= rd_q;
                vec_out          <= 1'b1;
                regWrite_out     <= rw_q;
                memWrite_out     <= mw_q;
                resultSrc_out    <= rs_q;
                updateCount_out  <= uc_q;
                branch_taken_out <= bt_q;
                lane_cnt         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vec_exe_sequencer.sv
// Scoreboard bench: stimulus pushes expected bundles, a negedge monitor pops them.
module tb_vec_exe_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vec_in, regWrite_in, memWrite_in, branch_in, resultSrc_in, updateCount_in;
    logic [3:0]  aluControl_in;
    logic [3:0]  rd_in;
    logic [15:0] op1_in, op2_in;
    logic [15:0] op01_in, op02_in, op11_in, op12_in, op21_in, op22_in, op31_in, op32_in;
    logic        hold_in;
    logic        stall, out_valid;
    logic [15:0] res_out, res0_out, res1_out, res2_out, res3_out;
    logic [3:0]  rd_out;
    logic        vec_out, regWrite_out, memWrite_out, resultSrc_out, updateCount_out;
    logic        branch_taken_out;

    vec_exe_sequencer #(.WIDTH(16), .LANES(4), .RD_W(4)) dut (
        .clk(clk), .reset(reset), .vec_in(vec_in),
        .regWrite_in(regWrite_in), .memWrite_in(memWrite_in), .branch_in(branch_in),
        .resultSrc_in(resultSrc_in), .updateCount_in(updateCount_in),
        .aluControl_in(aluControl_in), .rd_in(rd_in),
        .op1_in(op1_in), .op2_in(op2_in),
        .op01_in(op01_in), .op02_in(op02_in), .op11_in(op11_in), .op12_in(op12_in),
        .op21_in(op21_in), .op22_in(op22_in), .op31_in(op31_in), .op32_in(op32_in),
        .hold_in(hold_in), .stall(stall), .out_valid(out_valid),
        .res_out(res_out), .res0_out(res0_out), .res1_out(res1_out),
        .res2_out(res2_out), .res3_out(res3_out), .rd_out(rd_out),
        .vec_out(vec_out), .regWrite_out(regWrite_out), .memWrite_out(memWrite_out),
        .resultSrc_out(resultSrc_out), .updateCount_out(updateCount_out),
        .branch_taken_out(branch_taken_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic        vec;
        logic [15:0] res;
        logic [15:0] r0, r1, r2, r3;
        logic [3:0]  rd;
        logic        rw, mw, rs, uc, bt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_res;
    logic [15:0] m_lane [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_bubble();
        vec_in = 1'b0; regWrite_in = 1'b0; memWrite_in = 1'b0; branch_in = 1'b0;
        resultSrc_in = 1'b0; updateCount_in = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_stall"}, 32'(stall), 0);
        check({tag, "_res"}, 32'(res_out), 0);
        check({tag, "_res0"}, 32'(res0_out), 0);
        check({tag, "_res1"}, 32'(res1_out), 0);
        check({tag, "_res2"}, 32'(res2_out), 0);
        check({tag, "_res3"}, 32'(res3_out), 0);
        check({tag, "_rd"}, 32'(rd_out), 0);
        check({tag, "_flags"}, 32'({vec_out, regWrite_out, memWrite_out, resultSrc_out,
                                   updateCount_out, branch_taken_out}), 0);
    endtask

    task automatic issue_scalar(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] rd, input logic rw, input logic mw,
                                input logic br, input logic rs, input logic uc,
                                input logic [15:0] exp_res);
        exp_t e;
        vec_in = 1'b0; aluControl_in = op; op1_in = a; op2_in = b; rd_in = rd;
        regWrite_in = rw; memWrite_in = mw; branch_in = br; resultSrc_in = rs; updateCount_in = uc;
        m_res = exp_res;
        e.at = cyc + 1; e.vec = 1'b0; e.res = exp_res;
        e.r0 = m_lane[0]; e.r1 = m_lane[1]; e.r2 = m_lane[2]; e.r3 = m_lane[3];
        e.rd = rd; e.rw = rw; e.mw = mw; e.rs = rs; e.uc = uc; e.bt = br && (a == b);
        sb.push_back(e);
        check("scalar_stall", 32'(stall), 0);
        @(posedge clk); #1;
    endtask

    task automatic issue_vector(input logic [3:0] op, input logic [3:0][15:0] a,
                                input logic [3:0][15:0] b, input logic [3:0][15:0] exp_l,
                                input logic [3:0] rd, input int hold_at, input int hold_len);
        exp_t e;
        vec_in = 1'b1; aluControl_in = op; rd_in = rd;
        regWrite_in = 1'b1; memWrite_in = 1'b0; branch_in = 1'b0;
        resultSrc_in = 1'b1; updateCount_in = 1'b0;
        op1_in = 16'h0001; op2_in = 16'h0002;
        op01_in = a[0]; op02_in = b[0]; op11_in = a[1]; op12_in = b[1];
        op21_in = a[2]; op22_in = b[2]; op31_in = a[3]; op32_in = b[3];
        for (int i = 0; i < 4; i++) m_lane[i] = exp_l[i];
        e.at = cyc + 5 + hold_len; e.vec = 1'b1; e.res = m_res;
        e.r0 = exp_l[0]; e.r1 = exp_l[1]; e.r2 = exp_l[2]; e.r3 = exp_l[3];
        e.rd = rd; e.rw = 1'b1; e.mw = 1'b0; e.rs = 1'b1; e.uc = 1'b0; e.bt = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        drive_bubble();
        for (int k = 1; k <= 4 + hold_len; k++) begin
            if (hold_len > 0 && k == hold_at) hold_in = 1'b1;
            if (hold_len > 0 && k == hold_at + hold_len) hold_in = 1'b0;
            check("vector_stall_busy", 32'(stall), 1);
            @(posedge clk); #1;
        end
        check("vector_stall_released", 32'(stall), 0);
    endtask

    // Monitor: every out_valid cycle must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("latency", 32'(cyc), 32'(e.at));
                    check("vec_out", 32'(vec_out), 32'(e.vec));
                    check("res_out", 32'(res_out), 32'(e.res));
                    check("res0_out", 32'(res0_out), 32'(e.r0));
                    check("res1_out", 32'(res1_out), 32'(e.r1));
                    check("res2_out", 32'(res2_out), 32'(e.r2));
                    check("res3_out", 32'(res3_out), 32'(e.r3));
                    check("rd_out", 32'(rd_out), 32'(e.rd));
                    check("flags_out", 32'({regWrite_out, memWrite_out, resultSrc_out, updateCount_out}),
                          32'({e.rw, e.mw, e.rs, e.uc}));
                    check("branch_taken_out", 32'(branch_taken_out), 32'(e.bt));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; hold_in = 1'b0;
        drive_bubble();
        aluControl_in = '0; rd_in = '0; op1_in = '0; op2_in = '0;
        op01_in = '0; op02_in = '0; op11_in = '0; op12_in = '0;
        op21_in = '0; op22_in = '0; op31_in = '0; op32_in = '0;
        m_res = '0;
        for (int i = 0; i < 4; i++) m_lane[i] = '0;

        repeat (2) @(posedge clk);
        #1 check_zero("reset_held");
        reset = 1'b0;
        @(posedge clk); #1;
        check_zero("after_release");

        // Back-to-back scalars, one per cycle.
        issue_scalar(4'd0, 16'h1234, 16'h0001, 4'd5, 1, 0, 0, 0, 0, 16'h1235);
        issue_scalar(4'd7, 16'h8001, 16'h0001, 4'd1, 1, 0, 0, 0, 0, 16'h0003);
        issue_scalar(4'd6, 16'hF000, 16'h0013, 4'd2, 0, 1, 0, 0, 0, 16'h1E00);
        issue_scalar(4'd1, 16'h0000, 16'h0001, 4'd3, 0, 0, 0, 1, 1, 16'hFFFF);
        issue_scalar(4'd2, 16'hF0F0, 16'h3C3C, 4'd4, 1, 0, 0, 0, 0, 16'h3030);
        issue_scalar(4'd3, 16'h0F00, 16'h00F0, 4'd6, 1, 0, 0, 1, 0, 16'h0FF0);
        issue_scalar(4'd5, 16'h0001, 16'h000F, 4'd7, 1, 0, 0, 0, 0, 16'h8000);
        issue_scalar(4'd8, 16'h0001, 16'h0004, 4'd8, 1, 0, 0, 0, 0, 16'h1000);
        issue_scalar(4'd12, 16'hBEEF, 16'h1111, 4'd9, 1, 0, 0, 0, 0, 16'hBEEF);
        issue_scalar(4'd0, 16'h4444, 16'h4444, 4'd10, 0, 0, 1, 0, 0, 16'h8888);
        issue_scalar(4'd1, 16'h0005, 16'h0003, 4'd11, 0, 0, 1, 0, 0, 16'h0002);
        drive_bubble();
        @(posedge clk); #1;

        issue_vector(4'd4, {16'h0000, 16'h1234, 16'hFFFF, 16'hAAAA},
                     {16'h8001, 16'h1234, 16'h0F0F, 16'h5555},
                     {16'h8001, 16'h0000, 16'hF0F0, 16'hFFFF}, 4'd7, 0, 0);
        issue_vector(4'd0, {16'h1000, 16'h7FFF, 16'hFFFF, 16'h0001},
                     {16'h0100, 16'h0001, 16'h0001, 16'h0002},
                     {16'h1100, 16'h8000, 16'h0000, 16'h0003}, 4'd12, 0, 0);
        issue_vector(4'd0, {16'h1000, 16'h7FFF, 16'hFFFF, 16'h0001},
                     {16'h0100, 16'h0001, 16'h0001, 16'h0002},
                     {16'h1100, 16'h8000, 16'h0000, 16'h0003}, 4'd12, 3, 3);
        // A scalar right after a vector must leave the lane results alone.
        issue_scalar(4'd4, 16'h00FF, 16'h0F0F, 4'd13, 1, 0, 0, 0, 0, 16'h0FF0);

        // Bubbles, scalar and vector flavoured: no out_valid, nothing disturbed.
        drive_bubble();
        vec_in = 1'b1; op1_in = 16'h7777; op2_in = 16'h1111; aluControl_in = 4'd0;
        @(posedge clk); #1;
        vec_in = 1'b0;
        @(posedge clk); #1;
        check("bubble_out_valid", 32'(out_valid), 0);
        check("bubble_no_run", 32'(stall), 0);
        check("bubble_res_kept", 32'(res_out), 32'(m_res));
        check("bubble_lane_kept", 32'(res0_out), 32'(m_lane[0]));

        // Reset while lane 2 is being computed discards the vector.
        vec_in = 1'b1; regWrite_in = 1'b1; aluControl_in = 4'd1; rd_in = 4'd14;
        op01_in = 16'h1111; op02_in = 16'h0001; op11_in = 16'h2222; op12_in = 16'h0002;
        op21_in = 16'h3333; op22_in = 16'h0003; op31_in = 16'h4444; op32_in = 16'h0004;
        @(posedge clk); #1;
        drive_bubble();
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("pre_reset_busy", 32'(stall), 1);
        #2 reset = 1'b1;
        #1 check_zero("mid_run_reset");
        m_res = '0;
        for (int i = 0; i < 4; i++) m_lane[i] = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_reset_stall", 32'(stall), 0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("no_valid_for_discarded", 32'(out_valid), 0);
        issue_scalar(4'd0, 16'h0100, 16'h0023, 4'd15, 1, 0, 0, 0, 0, 16'h0123);
        drive_bubble();

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
